lcd_hex_writer: RTL and testbench
=================================

LCD_HEX_WRITER -- requirements
Module: lcd_hex_writer

Interface
REQ-001 Parameter T_POR, 750000, power-on wait in clk cycles (15 ms at 50 MHz).
REQ-002 Parameter T_EHI, 12, E high time in cycles (240 ns).
REQ-003 Parameter T_NIB, 50, gap after each nibble in cycles (1 us).
REQ-004 Parameter T_CMD, 2000, wait after each full command or data byte in cycles (40 us).
REQ-005 Parameter T_CLR, 82000, wait after Clear Display in cycles (1.64 ms).
REQ-006 clk  in  1  single clock; one clock, reset synchronous active-high.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  producer has a result to display.
REQ-009 in_data  in  5  {carry, sum[3:0]} from the 4-bit adder stage.
REQ-010 in_ready  out  1  block accepts in_data this cycle.
REQ-011 sf_e  out  1  LCD select (1 = LCD, StrataFlash disabled).
REQ-012 e  out  1  LCD enable strobe.
REQ-013 rs  out  1  register select (0 = command, 1 = data).
REQ-014 rw  out  1  read/write (write only).
REQ-015 lcd_d  out  4  data nibble {d,c,b,a}.

Function
REQ-016 sf_e SHALL be 1 and rw SHALL be 0 in every cycle, including reset.
REQ-017 Each byte SHALL be sent as upper nibble then lower nibble; each nibble: rs/lcd_d stable 2 cycles before e rises, e high T_EHI cycles, rs/lcd_d held 1 cycle after e falls, then T_NIB idle cycles.
REQ-018 After a byte's lower nibble, the block SHALL wait T_CMD cycles, or T_CLR if the byte was 0x01, before the next byte.
REQ-019 FSM states SHALL be POR_WAIT, INIT, CFG, IDLE, SET_ADDR, WR_HI, WR_LO.
REQ-020 POR_WAIT: count T_POR cycles, then go to INIT.
REQ-021 INIT: send single nibbles 0x3, 0x3, 0x3, 0x2 (rs=0), each followed by T_CMD wait, then go to CFG.
REQ-022 CFG: send bytes 0x28, 0x06, 0x0C, 0x01 (rs=0), then go to IDLE.
REQ-023 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid && in_ready.
REQ-024 On transfer, in_data SHALL be captured into a 5-bit register and the FSM SHALL move to SET_ADDR the next cycle; later in_data changes do not affect the current write.
REQ-025 SET_ADDR: send command 0x80 (DDRAM address 0).
REQ-026 WR_HI: send data byte (rs=1) for ASCII of captured[4] ('0'=0x30 or '1'=0x31).
REQ-027 WR_LO: send data byte (rs=1) for ASCII hex of captured[3:0]: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46; then return to IDLE.
REQ-028 Display SHALL read "00" through "1F"; no other characters are written after init.
REQ-029 in_valid asserted during POR_WAIT/INIT/CFG SHALL be held off by in_ready=0, with nothing lost or duplicated.
REQ-030 Back-to-back in_valid SHALL be accepted once per visit to IDLE; IDLE lasts at least 1 cycle.

Reset
REQ-031 rst SHALL force POR_WAIT with counters 0, e=0, rs=0, lcd_d=0, in_ready=0, and the capture register 0.
REQ-032 rst asserted at any point, including mid-nibble with e high, SHALL drop e in the next cycle and restart the full T_POR plus init sequence.

Structure
REQ-033 The FSM state encoding and the init/config command constants (0x3, 0x2, 0x28, 0x06, 0x0C, 0x01, 0x80) SHALL live in a shared package, lcd_pkg.
REQ-034 The per-nibble timing of REQ-017 and REQ-018 SHALL be one sub-module, lcd_nibble_tx, with start/busy handshake, rs, nibble, and long_wait inputs.
REQ-035 The top FSM SHALL sequence bytes only and never drive e directly.

Verification (all with T_POR=20, T_EHI=3, T_NIB=2, T_CMD=5, T_CLR=8)
REQ-036 Reset, then idle: nibbles 3,3,3,2 then bytes 28,06,0C,01 with rs=0; in_ready rises after the last T_CLR wait.
REQ-037 in_data=5'h0B with valid in IDLE -> bytes 80 (rs=0), 30, 42 (rs=1); in_ready returns to 1.
REQ-038 in_data=5'h1F -> data bytes 31, 46; in_data=5'h09 -> 30, 39.
REQ-039 in_valid held from reset with in_data=5'h10 -> exactly one write, 31 30, after init.
REQ-040 rst pulsed while e=1 during WR_HI -> e=0 next cycle, sf_e=1 throughout, full init sequence repeats.
REQ-041 Every nibble checks e-high width = T_EHI, setup >= 2, and hold >= 1 cycles, with lcd_d stable while e=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD hex writer.
// Holds the top-level sequencer state encoding, the nibble transmitter
// phase encoding, the HD44780 init/config command constants and the
// nibble-to-ASCII helper used when writing the hex digit.
package lcd_pkg;

    typedef enum logic [2:0] {
        POR_WAIT,
        INIT,
        CFG,
        IDLE,
        SET_ADDR,
        WR_HI,
        WR_LO
    } lcd_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_EHI,
        TX_HOLD,
        TX_GAP,
        TX_WAIT
    } tx_state_t;

    // Power-up handshake: three "8-bit mode" nibbles, then switch to 4-bit.
    localparam logic [3:0] INIT_NIB_8BIT   = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT   = 4'h2;

    localparam logic [7:0] CMD_FUNC_SET    = 8'h28;  // 4-bit, 2 lines, 5x8
    localparam logic [7:0] CMD_ENTRY_MODE  = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_DISP_ON     = 8'h0C;  // display on, no cursor
    localparam logic [7:0] CMD_CLEAR       = 8'h01;  // needs the long wait
    localparam logic [7:0] CMD_DDRAM_ADDR0 = 8'h80;  // cursor to column 0

    localparam logic [7:0] ASCII_ZERO      = 8'h30;

    // Nibble counts per sequencer state (single nibbles in INIT, 2 per byte).
    localparam logic [3:0] INIT_STEPS      = 4'd4;
    localparam logic [3:0] CFG_STEPS       = 4'd8;
    localparam logic [3:0] BYTE_STEPS      = 4'd2;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_ENTRY_MODE;
            2'd2:    return CMD_DISP_ON;
            default: return CMD_CLEAR;
        endcase
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        if (v < 4'd10) begin
            return ASCII_ZERO + {4'h0, v};
        end
        return 8'h37 + {4'h0, v};  // 'A' - 10
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one 4-bit nibble to the LCD with the bus timing the controller needs:
// rs/lcd_d set up 2 cycles before e rises, e high T_EHI cycles, data held
// 1 cycle after e falls, then T_NIB idle cycles.  When byte_end is set the
// transmitter additionally waits T_CMD (or T_CLR when long_wait is set)
// before reporting not-busy, so the caller only sequences bytes.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            request a nibble; taken only while busy is low
//   rs_in, nibble    register select and nibble for the request
//   byte_end         this nibble completes a command/data byte
//   long_wait        use T_CLR instead of T_CMD for the end-of-byte wait
//   busy             transmitter is working on a nibble
//   e, rs, lcd_d     LCD bus outputs
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_EHI = 12,
    parameter int unsigned T_NIB = 50,
    parameter int unsigned T_CMD = 2000,
    parameter int unsigned T_CLR = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs_in,
    input  logic [3:0] nibble,
    input  logic       byte_end,
    input  logic       long_wait,
    output logic       busy,
    output logic       e,
    output logic       rs,
    output logic [3:0] lcd_d
);

    localparam logic [31:0] SETUP_CYC = 32'd2;

    tx_state_t   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rs_q, rs_d;
    logic [3:0]  nib_q, nib_d;
    logic        end_q, end_d;
    logic        long_q, long_d;
    logic        e_q, e_d;
    logic [31:0] wait_len;

    assign wait_len = long_q ? T_CLR : T_CMD;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        rs_d    = rs_q;
        nib_d   = nib_q;
        end_d   = end_q;
        long_d  = long_q;

        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = TX_SETUP;
                    rs_d    = rs_in;
                    nib_d   = nibble;
                    end_d   = byte_end;
                    long_d  = long_wait;
                end
            end
            TX_SETUP: begin
                if (cnt_q == SETUP_CYC - 32'd1) begin
                    state_d = TX_EHI;
                    cnt_d   = '0;
                end
            end
            TX_EHI: begin
                if (cnt_q == T_EHI - 32'd1) begin
                    state_d = TX_HOLD;
                    cnt_d   = '0;
                end
            end
            TX_HOLD: begin
                state_d = TX_GAP;
                cnt_d   = '0;
            end
            TX_GAP: begin
                if (cnt_q == T_NIB - 32'd1) begin
                    state_d = end_q ? TX_WAIT : TX_IDLE;
                    cnt_d   = '0;
                end
            end
            TX_WAIT: begin
                if (cnt_q == wait_len - 32'd1) begin
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = '0;
            end
        endcase

        // e is registered from the next state so the strobe is glitch-free.
        e_d = (state_d == TX_EHI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            nib_q   <= '0;
            end_q   <= 1'b0;
            long_q  <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            nib_q   <= nib_d;
            end_q   <= end_d;
            long_q  <= long_d;
            e_q     <= e_d;
        end
    end

    assign busy  = (state_q != TX_IDLE);
    assign e     = e_q;
    assign rs    = rs_q;
    assign lcd_d = nib_q;

endmodule

// File: rtl/lcd_hex_writer.sv
// Shows a 5-bit adder result {carry, sum[3:0]} as two hex characters
// ("00".."1F") at column 0 of a 4-bit-bus HD44780 character LCD.
// After reset it waits T_POR cycles, runs the 4-bit init handshake and the
// configuration bytes, then accepts one result per visit to IDLE.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready valid/ready handshake for in_data
//   in_data           {carry, sum[3:0]}
//   sf_e              1 selects the LCD (shared bus with StrataFlash)
//   e, rs, rw, lcd_d  LCD bus (write only, rw tied low)
module lcd_hex_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_POR = 750000,
    parameter int unsigned T_EHI = 12,
    parameter int unsigned T_NIB = 50,
    parameter int unsigned T_CMD = 2000,
    parameter int unsigned T_CLR = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] in_data,
    output logic       in_ready,
    output logic       sf_e,
    output logic       e,
    output logic       rs,
    output logic       rw,
    output logic [3:0] lcd_d
);

    lcd_state_t  state_q, state_d;
    logic [31:0] por_cnt_q, por_cnt_d;
    logic [3:0]  sub_q, sub_d;     // nibble index within the current state
    logic [4:0]  cap_q, cap_d;

    logic        tx_start;
    logic        tx_rs;
    logic [3:0]  tx_nib;
    logic        tx_end;
    logic        tx_long;
    logic        tx_busy;
    logic [7:0]  cur_byte;
    logic [3:0]  last_step;

    always_comb begin
        state_d   = state_q;
        por_cnt_d = por_cnt_q;
        sub_d     = sub_q;
        cap_d     = cap_q;
        tx_start  = 1'b0;

        case (state_q)
            CFG:      cur_byte = cfg_byte(sub_q[2:1]);
            SET_ADDR: cur_byte = CMD_DDRAM_ADDR0;
            WR_HI:    cur_byte = ASCII_ZERO | {7'h00, cap_q[4]};
            WR_LO:    cur_byte = hex_ascii(cap_q[3:0]);
            default:  cur_byte = 8'h00;
        endcase

        case (state_q)
            INIT:    last_step = INIT_STEPS;
            CFG:     last_step = CFG_STEPS;
            default: last_step = BYTE_STEPS;
        endcase

        tx_rs = (state_q == WR_HI) || (state_q == WR_LO);

        // INIT sends lone nibbles, each followed by the command wait;
        // everything else is upper nibble (no wait) then lower nibble.
        if (state_q == INIT) begin
            tx_nib = (sub_q == 4'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
            tx_end = 1'b1;
        end else begin
            tx_nib = sub_q[0] ? cur_byte[3:0] : cur_byte[7:4];
            tx_end = sub_q[0];
        end
        tx_long = tx_end && !tx_rs && (cur_byte == CMD_CLEAR);

        case (state_q)
            POR_WAIT: begin
                if (por_cnt_q == T_POR - 32'd1) begin
                    state_d   = INIT;
                    por_cnt_d = '0;
                end else begin
                    por_cnt_d = por_cnt_q + 32'd1;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    cap_d   = in_data;
                    state_d = SET_ADDR;
                end
            end
            INIT, CFG, SET_ADDR, WR_HI, WR_LO: begin
                // Advance only once the previous nibble and its wait are done.
                if (!tx_busy) begin
                    if (sub_q == last_step) begin
                        sub_d = '0;
                        case (state_q)
                            INIT:     state_d = CFG;
                            CFG:      state_d = IDLE;
                            SET_ADDR: state_d = WR_HI;
                            WR_HI:    state_d = WR_LO;
                            default:  state_d = IDLE;
                        endcase
                    end else begin
                        tx_start = 1'b1;
                        sub_d    = sub_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = POR_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= POR_WAIT;
            por_cnt_q <= '0;
            sub_q     <= '0;
            cap_q     <= '0;
        end else begin
            state_q   <= state_d;
            por_cnt_q <= por_cnt_d;
            sub_q     <= sub_d;
            cap_q     <= cap_d;
        end
    end

    lcd_nibble_tx #(
        .T_EHI(T_EHI),
        .T_NIB(T_NIB),
        .T_CMD(T_CMD),
        .T_CLR(T_CLR)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (tx_start),
        .rs_in    (tx_rs),
        .nibble   (tx_nib),
        .byte_end (tx_end),
        .long_wait(tx_long),
        .busy     (tx_busy),
        .e        (e),
        .rs       (rs),
        .lcd_d    (lcd_d)
    );

    assign in_ready = (state_q == IDLE);
    assign sf_e     = 1'b1;
    assign rw       = 1'b0;

endmodule

// File: tb/tb_lcd_hex_writer.sv
module tb_lcd_hex_writer;

    localparam int unsigned T_POR = 20;
    localparam int unsigned T_EHI = 3;
    localparam int unsigned T_NIB = 2;
    localparam int unsigned T_CMD = 5;
    localparam int unsigned T_CLR = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] in_data = 5'd0;
    logic       in_ready;
    logic       sf_e;
    logic       e;
    logic       rs;
    logic       rw;
    logic [3:0] lcd_d;

    int n_checks = 0;
    int n_errors = 0;

    // Observed and expected nibble streams, each entry {rs, nibble}.
    int nib_q[$];
    int exp_q[$];

    int         stable_cnt = 0;
    int         ehi_w = 0;
    int         cyc_since_fall = 0;
    logic       in_e = 1'b0;
    logic [4:0] e_data = 5'd0;
    logic [4:0] prev_bus = 5'd0;

    lcd_hex_writer #(
        .T_POR(T_POR),
        .T_EHI(T_EHI),
        .T_NIB(T_NIB),
        .T_CMD(T_CMD),
        .T_CLR(T_CLR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .sf_e    (sf_e),
        .e       (e),
        .rs      (rs),
        .rw      (rw),
        .lcd_d   (lcd_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: samples on the falling edge, checks nibble timing and
    // collects every strobed nibble.
    always @(negedge clk) begin
        logic [4:0] cur;
        cur = {rs, lcd_d};
        cyc_since_fall++;
        check("sf_e_rw", {30'd0, sf_e, rw}, 32'h2);
        if (rst) begin
            in_e       = 1'b0;
            ehi_w      = 0;
            stable_cnt = 0;
        end else begin
            if (cur === prev_bus) stable_cnt++;
            else stable_cnt = 1;
            if (e && !in_e) begin
                check("setup_ge2", {31'd0, (stable_cnt >= 3)}, 32'd1);
                in_e   = 1'b1;
                ehi_w  = 1;
                e_data = cur;
            end else if (e && in_e) begin
                ehi_w++;
                check("data_stable_e", {27'd0, cur}, {27'd0, e_data});
            end else if (!e && in_e) begin
                in_e = 1'b0;
                check("e_high_width", ehi_w, T_EHI);
                check("hold_ge1", {27'd0, cur}, {27'd0, e_data});
                nib_q.push_back(int'(e_data));
                cyc_since_fall = 0;
            end
        end
        prev_bus = cur;
    end

    // Reference model: what the display should receive.
    function automatic void push_nib(input int r, input int n);
        exp_q.push_back(r * 16 + n);
    endfunction

    function automatic void push_byte(input int r, input int b);
        push_nib(r, b / 16);
        push_nib(r, b % 16);
    endfunction

    function automatic void model_init();
        push_nib(0, 3);
        push_nib(0, 3);
        push_nib(0, 3);
        push_nib(0, 2);
        push_byte(0, 'h28);
        push_byte(0, 'h06);
        push_byte(0, 'h0C);
        push_byte(0, 'h01);
    endfunction

    function automatic void model_write(input int v);
        int lo;
        lo = v % 16;
        push_byte(0, 'h80);
        push_byte(1, 48 + v / 16);
        push_byte(1, (lo < 10) ? (48 + lo) : (55 + lo));
    endfunction

    task automatic check_stream(input string tag);
        int n;
        check({tag, "_count"}, nib_q.size(), exp_q.size());
        n = (nib_q.size() < exp_q.size()) ? nib_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_nib%0d", tag, i), nib_q[i], exp_q[i]);
        end
        nib_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int k;
        k = 0;
        while (!in_ready && k < budget) begin
            step();
            k++;
        end
        check(tag, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [4:0] v);
        wait_ready("ready_before_write", 3000);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
        in_data  = 5'($urandom);
        check("ready_low_after_accept", {31'd0, in_ready}, 32'd0);
        model_write(int'(v));
        wait_ready("ready_after_write", 3000);
        check_stream($sformatf("write_%0h", v));
    endtask

    initial begin
        logic       seen_e;
        logic       found;
        logic [4:0] directed [6];
        int         k;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_e", {31'd0, e}, 32'd0);
        check("rst_rs", {31'd0, rs}, 32'd0);
        check("rst_lcd_d", {28'd0, lcd_d}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_sf_e", {31'd0, sf_e}, 32'd1);
        check("rst_rw", {31'd0, rw}, 32'd0);
        rst = 1'b0;

        // Power-on wait: no strobe for T_POR cycles
        seen_e = 1'b0;
        for (int i = 0; i < int'(T_POR); i++) begin
            step();
            seen_e = seen_e | e | in_ready;
        end
        check("por_quiet", {31'd0, seen_e}, 32'd0);

        // Init and config sequence
        model_init();
        wait_ready("ready_after_init", 3000);
        check("clear_wait_before_ready", {31'd0, (cyc_since_fall >= int'(T_NIB + T_CLR + 1))}, 32'd1);
        check_stream("init");

        // Directed writes, including boundary values
        directed[0] = 5'h0B;
        directed[1] = 5'h1F;
        directed[2] = 5'h09;
        directed[3] = 5'h00;
        directed[4] = 5'h0A;
        directed[5] = 5'h10;
        for (int i = 0; i < 6; i++) begin
            do_write(directed[i]);
        end

        // Randomized writes
        for (int i = 0; i < 8; i++) begin
            do_write(5'($urandom_range(0, 31)));
        end

        // in_valid held through reset and init: exactly one write
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'h10;
        repeat (3) step();
        nib_q.delete();
        exp_q.delete();
        rst = 1'b0;
        model_init();
        model_write('h10);
        wait_ready("held_valid_ready", 3000);
        step();
        in_valid = 1'b0;
        check("held_valid_accepted", {31'd0, in_ready}, 32'd0);
        wait_ready("held_valid_done", 3000);
        repeat (40) step();
        check_stream("held_valid");

        // Reset with e high during WR_HI
        in_valid = 1'b1;
        in_data  = 5'($urandom);
        step();
        in_valid = 1'b0;
        found = 1'b0;
        k = 0;
        while (!found && k < 500) begin
            step();
            k++;
            found = e && rs;
        end
        check("found_e_high_wr_hi", {31'd0, found}, 32'd1);
        rst = 1'b1;
        step();
        check("rst_mid_nibble_e", {31'd0, e}, 32'd0);
        check("rst_mid_nibble_sf_e", {31'd0, sf_e}, 32'd1);
        step();
        rst = 1'b0;
        nib_q.delete();
        exp_q.delete();
        seen_e = 1'b0;
        for (int i = 0; i < int'(T_POR); i++) begin
            step();
            seen_e = seen_e | e | in_ready;
        end
        check("por_quiet_again", {31'd0, seen_e}, 32'd0);
        model_init();
        wait_ready("ready_after_reinit", 3000);
        check_stream("reinit");
        do_write(5'($urandom_range(0, 31)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
